// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared constants for the i2c_master_v3 block: FSM state
//                encoding, SCL quarter-phase codes and parameter limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

   // FSM state encoding
   localparam int         ST_W       = 4;
   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_START   = 4'd1;
   localparam logic [3:0] ST_DEV_W   = 4'd2;
   localparam logic [3:0] ST_ACK_DW  = 4'd3;
   localparam logic [3:0] ST_REG     = 4'd4;
   localparam logic [3:0] ST_ACK_REG = 4'd5;
   localparam logic [3:0] ST_WDATA   = 4'd6;
   localparam logic [3:0] ST_ACK_WD  = 4'd7;
   localparam logic [3:0] ST_RSTART  = 4'd8;
   localparam logic [3:0] ST_DEV_R   = 4'd9;
   localparam logic [3:0] ST_ACK_DR  = 4'd10;
   localparam logic [3:0] ST_RDATA   = 4'd11;
   localparam logic [3:0] ST_MACK    = 4'd12;
   localparam logic [3:0] ST_STOP    = 4'd13;
   localparam logic [3:0] ST_DONE    = 4'd14;

   // SCL quarter phases: Q0/Q1 SCL low, Q2/Q3 SCL high, sample in Q2
   localparam logic [1:0] QP0 = 2'd0;
   localparam logic [1:0] QP1 = 2'd1;
   localparam logic [1:0] QP2 = 2'd2;
   localparam logic [1:0] QP3 = 2'd3;

   // Legal parameter ranges
   localparam int CLK_DIV_MIN    = 2;
   localparam int CLK_DIV_MAX    = 65535;
   localparam int ADDR_BYTES_MIN = 0;
   localparam int ADDR_BYTES_MAX = 2;
   localparam int DATA_BYTES_MIN = 1;
   localparam int DATA_BYTES_MAX = 4;

endpackage
`default_nettype wire

// File: rtl/i2c_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bit_timer
//  Description : Divides clk into SCL quarter ticks and tracks the quarter
//                phase of the current bit. With I2C_CLK_STRETCH_EN defined the
//                timer holds in Q2 while the sensed SCL line is still low.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_bit_timer
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 250
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_run,
`ifdef I2C_CLK_STRETCH_EN
   input  logic       i_scl,
`endif
   output logic       o_tick,
   output logic [1:0] o_phase
);

   localparam logic [15:0] CNT_LAST = 16'(CLK_DIV - 1);

   logic [15:0] r_cnt;
   logic [1:0]  r_phase;
   logic        w_hold;

   // Stretch hold: a slave keeping SCL low freezes the high quarter
   always_comb begin
`ifdef I2C_CLK_STRETCH_EN
      w_hold = i_run && (r_phase == QP2) && !i_scl;
`else
      w_hold = 1'b0;
`endif
   end

   assign o_tick  = i_run && !w_hold && (r_cnt == CNT_LAST);
   assign o_phase = r_phase;

   // Quarter counter and phase; cleared whenever the master is not running
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= 16'd0;
         r_phase <= QP0;
      end else if (!i_run) begin
         r_cnt   <= 16'd0;
         r_phase <= QP0;
      end else if (!w_hold) begin
         if (r_cnt == CNT_LAST) begin
            r_cnt   <= 16'd0;
            r_phase <= r_phase + 2'd1;
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/i2c_master_v3.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_master_v3
//  Description : I2C register-access master. Write: S, dev+W, reg bytes, data
//                bytes, P. Read: S, dev+W, reg bytes, Sr, dev+R, data bytes
//                (master ACK all but last), P. Slave NACK aborts to STOP.
//                Optional clock stretching via macro I2C_CLK_STRETCH_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_master_v3
   import i2c_pkg::*;
#(
   parameter int CLK_DIV    = 250,
   parameter int ADDR_BYTES = 1,
   parameter int DATA_BYTES = 2
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          start,
   input  logic                                          rw,
   input  logic [6:0]                                    dev_addr,
   input  logic [8*((ADDR_BYTES == 0) ? 1 : ADDR_BYTES)-1:0] reg_addr,
   input  logic [8*DATA_BYTES-1:0]                       wdata,
   output logic [8*DATA_BYTES-1:0]                       rdata,
   output logic                                          busy,
   output logic                                          done,
   output logic                                          nack_err,
   output logic                                          scl,
   output logic                                          o_sda,
`ifdef I2C_CLK_STRETCH_EN
   input  logic                                          i_scl,
`endif
   input  logic                                          i_sda,
   output logic                                          drv
);

   localparam int         RA_N     = (ADDR_BYTES == 0) ? 1 : ADDR_BYTES;
   localparam int         DW       = 8 * DATA_BYTES;
   localparam logic [1:0] LAST_REG = 2'(RA_N - 1);
   localparam logic [1:0] LAST_DAT = 2'(DATA_BYTES - 1);

   logic [ST_W-1:0]  r_state, w_next;
   logic [2:0]       r_bit;
   logic [1:0]       r_byte;
   logic             r_rw;
   logic [6:0]       r_dev;
   logic [8*RA_N-1:0] r_reg;
   logic [DW-1:0]    r_wdata;
   logic [DW-1:0]    r_rdata;
   logic [7:0]       r_rx;
   logic             r_ackbit;
   logic             r_nack;
   logic             w_run, w_tick, w_bnd, w_samp, w_more, w_txbit;
   logic [1:0]       w_phase, w_ridx, w_didx;
   logic [7:0]       w_txbyte;
   logic             w_scl, w_sda, w_drv;

   assign w_run  = (r_state != ST_IDLE) && (r_state != ST_DONE);
   assign w_bnd  = w_tick && (w_phase == QP3);
   assign w_samp = w_tick && (w_phase == QP2);
   assign w_ridx = LAST_REG - r_byte;
   assign w_didx = LAST_DAT - r_byte;

   i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_run   (w_run),
`ifdef I2C_CLK_STRETCH_EN
      .i_scl   (i_scl),
`endif
      .o_tick  (w_tick),
      .o_phase (w_phase)
   );

   // Byte currently being shifted out, and the bit of it on the wire
   always_comb begin
      w_txbyte = 8'h00;
      case (r_state)
         ST_DEV_W: w_txbyte = {r_dev, 1'b0};
         ST_DEV_R: w_txbyte = {r_dev, 1'b1};
         ST_REG:   w_txbyte = 8'(r_reg >> {w_ridx, 3'b000});
         ST_WDATA: w_txbyte = 8'(r_wdata >> {w_didx, 3'b000});
         default:  w_txbyte = 8'h00;
      endcase
      w_txbit = w_txbyte[3'd7 - r_bit];
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; byte states advance at each bit boundary
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (start) w_next = ST_START;
         ST_START:   if (w_bnd) w_next = (ADDR_BYTES == 0 && r_rw) ? ST_DEV_R : ST_DEV_W;
         ST_DEV_W:   if (w_bnd && r_bit == 3'd7) w_next = ST_ACK_DW;
         ST_ACK_DW:  if (w_bnd) w_next = r_ackbit ? ST_STOP :
                                         (ADDR_BYTES > 0) ? ST_REG : ST_WDATA;
         ST_REG:     if (w_bnd && r_bit == 3'd7) w_next = ST_ACK_REG;
         ST_ACK_REG: if (w_bnd) w_next = r_ackbit ? ST_STOP :
                                         (r_byte != LAST_REG) ? ST_REG :
                                         r_rw ? ST_RSTART : ST_WDATA;
         ST_WDATA:   if (w_bnd && r_bit == 3'd7) w_next = ST_ACK_WD;
         ST_ACK_WD:  if (w_bnd) w_next = (r_ackbit || r_byte == LAST_DAT) ? ST_STOP : ST_WDATA;
         ST_RSTART:  if (w_bnd) w_next = ST_DEV_R;
         ST_DEV_R:   if (w_bnd && r_bit == 3'd7) w_next = ST_ACK_DR;
         ST_ACK_DR:  if (w_bnd) w_next = r_ackbit ? ST_STOP : ST_RDATA;
         ST_RDATA:   if (w_bnd && r_bit == 3'd7) w_next = ST_MACK;
         ST_MACK:    if (w_bnd) w_next = (r_byte == LAST_DAT) ? ST_STOP : ST_RDATA;
         ST_STOP:    if (w_bnd) w_next = ST_DONE;
         ST_DONE:    w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   // Another byte of the same kind follows the acknowledge just completed
   assign w_more = ((r_state == ST_ACK_REG) && (w_next == ST_REG))   ||
                   ((r_state == ST_ACK_WD)  && (w_next == ST_WDATA)) ||
                   ((r_state == ST_MACK)    && (w_next == ST_RDATA));

   // Datapath: request capture, bit/byte counters, sampling, status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit    <= 3'd0;
         r_byte   <= 2'd0;
         r_rw     <= 1'b0;
         r_dev    <= 7'd0;
         r_reg    <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_rx     <= 8'd0;
         r_ackbit <= 1'b0;
         r_nack   <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         if (start) begin
            r_rw    <= rw;
            r_dev   <= dev_addr;
            r_reg   <= reg_addr;
            r_wdata <= wdata;
            r_rdata <= '0;
            r_nack  <= 1'b0;
            r_bit   <= 3'd0;
            r_byte  <= 2'd0;
         end
      end else begin
         if (w_samp) begin
            r_ackbit <= i_sda;
            if (r_state == ST_RDATA) r_rx <= {r_rx[6:0], i_sda};
         end
         if (w_bnd) begin
            r_bit <= (w_next == r_state) ? r_bit + 3'd1 : 3'd0;
            if (w_more)
               r_byte <= r_byte + 2'd1;
            else if (r_state == ST_ACK_DW || r_state == ST_ACK_REG || r_state == ST_ACK_DR)
               r_byte <= 2'd0;
            if ((r_state == ST_ACK_DW || r_state == ST_ACK_REG ||
                 r_state == ST_ACK_WD || r_state == ST_ACK_DR) && r_ackbit)
               r_nack <= 1'b1;
            if (r_state == ST_RDATA && r_bit == 3'd7)
               r_rdata <= r_rdata | (DW'(r_rx) << {w_didx, 3'b000});
         end
      end
   end

   // Bus drive per state and quarter; idle/reset leaves both lines released
   always_comb begin
      w_scl = 1'b1;
      w_sda = 1'b1;
      w_drv = 1'b0;
      case (r_state)
         ST_START: begin
            w_drv = 1'b1;
            w_sda = !w_phase[1];
         end
         ST_RSTART: begin
            w_drv = 1'b1;
            w_scl = (w_phase != QP0);
            w_sda = !w_phase[1];
         end
         ST_STOP: begin
            w_drv = 1'b1;
            w_scl = (w_phase != QP0);
            w_sda = w_phase[1];
         end
         ST_DONE: w_drv = 1'b1;
         ST_DEV_W, ST_DEV_R, ST_REG, ST_WDATA: begin
            w_drv = 1'b1;
            w_scl = w_phase[1];
            w_sda = w_txbit;
         end
         ST_ACK_DW, ST_ACK_REG, ST_ACK_WD, ST_ACK_DR, ST_RDATA: begin
            w_scl = w_phase[1];
         end
         ST_MACK: begin
            w_drv = 1'b1;
            w_scl = w_phase[1];
            w_sda = (r_byte == LAST_DAT);
         end
         default: ;
      endcase
   end

   assign scl      = w_scl;
   assign o_sda    = w_sda;
   assign drv      = w_drv;
   assign busy     = (r_state != ST_IDLE);
   assign done     = (r_state == ST_DONE);
   assign nack_err = r_nack;
   assign rdata    = r_rdata;

endmodule
`default_nettype wire
